// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED pattern controller: modes, bounce direction and seeds.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'd0,
        MODE_ROTR   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [15:0] SEED_SHIFT = 16'h0001;
    localparam logic [15:0] SEED_BLINK = 16'hFFFF;
    localparam logic [15:0] LED_TOP    = 16'h8000;
    localparam logic [15:0] LED_BOTTOM = 16'h0001;

    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

    function automatic logic [15:0] mode_seed(input mode_e m);
        return (m == MODE_BLINK) ? SEED_BLINK : SEED_SHIFT;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> debouncer -> one-cycle press pulse on a debounced rise.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic press
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Until a debounced low is seen after reset the block is disarmed, so a button
    // held through reset never yields a press (the two reset-low synchroniser
    // samples are shorter than any sensible DEBOUNCE_CYCLES).
    always_comb begin
        // NOTE: every _d gets a default first, so no branch can leave a latch behind.
        sync1_d  = btn_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        armed_d  = armed_q;
        press_d  = 1'b0;
        cnt_d    = cnt_q;

        if (!armed_q) begin
            if (sync2_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                armed_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            press_d  = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses <= so every flop samples the pre-edge values of the others.
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            armed_q  <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            armed_q  <= armed_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// 16-LED pattern generator: prescaled step tick, four modes, debounced mode and pause buttons.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CLK_HZ          = 10_000_000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_pause,
    output logic [15:0] led,
    output logic [1:0]  mode,
    output logic        paused,
    output logic        tick
);

    localparam int            DIV      = CLK_HZ / TICK_HZ;
    localparam int            PW       = $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic          mode_press, pause_press;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic [15:0]   led_q, led_d;
    mode_e         mode_q, mode_d;
    dir_e          dir_q, dir_d;
    logic          paused_q, paused_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_mode),
        .press  (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_pause),
        .press  (pause_press)
    );

    always_comb begin
        cnt_d    = (cnt_q == PRE_LAST) ? '0 : cnt_q + PW'(1);
        tick_d   = (cnt_q == PRE_LAST);
        led_d    = led_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        paused_d = paused_q;

        // A mode press outranks a coincident tick: reseed and restart the step interval.
        if (mode_press) begin
            mode_d = next_mode(mode_q);
            led_d  = mode_seed(mode_d);
            dir_d  = DIR_LEFT;
            cnt_d  = '0;
        end else if (tick_q && !paused_q) begin
            unique case (mode_q)
                MODE_ROTL:  led_d = {led_q[14:0], led_q[15]};
                MODE_ROTR:  led_d = {led_q[0], led_q[15:1]};
                MODE_BLINK: led_d = ~led_q;
                MODE_BOUNCE: begin
                    if (led_q == LED_TOP)         dir_d = DIR_RIGHT;
                    else if (led_q == LED_BOTTOM) dir_d = DIR_LEFT;
                    led_d = (dir_d == DIR_RIGHT) ? (led_q >> 1) : (led_q << 1);
                end
                default: ;
            endcase
        end

        if (pause_press) paused_d = ~paused_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            led_q    <= SEED_SHIFT;
            mode_q   <= MODE_ROTL;
            dir_q    <= DIR_LEFT;
            paused_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            led_q    <= led_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            paused_q <= paused_d;
        end
    end

    assign led    = led_q;
    assign mode   = mode_q;
    assign paused = paused_q;
    assign tick   = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl: directed scenarios plus random buttons/resets vs a reference model.
module tb_led_pattern_ctrl;

    localparam int DIV = 16;
    localparam int DB  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_mode = 1'b0;
    logic        btn_pause = 1'b0;
    logic [15:0] led;
    logic [1:0]  mode;
    logic        paused;
    logic        tick;

    int n_total = 0;
    int n_bad   = 0;

    led_pattern_ctrl #(
        .CLK_HZ          (DIV),
        .TICK_HZ         (1),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_pause (btn_pause),
        .led       (led),
        .mode      (mode),
        .paused    (paused),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    // Reference model: edge index, prescaler phase as "edge where the count was last 0",
    // buttons as a delay line plus a run length of samples that disagree with the level.
    int          e = 0;
    int          m_zero = 0;
    logic [15:0] m_led = 16'h0001;
    logic [1:0]  m_mode = 2'd0;
    logic        m_paused = 1'b0;
    logic        m_tick = 1'b0;
    logic        m_right = 1'b0;
    bit          d_s1[2], d_s2[2], d_stable[2], d_armed[2], d_press[2];
    int          d_run[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic deb_edge(input int b, input bit raw);
        bit sample;
        sample   = d_s2[b];
        d_s2[b]  = d_s1[b];
        d_s1[b]  = raw;
        d_press[b] = 1'b0;
        if (!d_armed[b]) begin
            d_run[b] = sample ? 0 : d_run[b] + 1;
            if (d_run[b] == DB) begin
                d_armed[b] = 1'b1;
                d_run[b]   = 0;
            end
        end else begin
            d_run[b] = (sample == d_stable[b]) ? 0 : d_run[b] + 1;
            if (d_run[b] == DB) begin
                d_stable[b] = sample;
                d_press[b]  = sample;
                d_run[b]    = 0;
            end
        end
    endtask

    task automatic model_edge();
        bit old_tick, pm, pp;
        e++;
        if (reset) begin
            m_led = 16'h0001; m_mode = 2'd0; m_paused = 1'b0; m_tick = 1'b0;
            m_right = 1'b0; m_zero = e;
            for (int b = 0; b < 2; b++) begin
                d_s1[b] = 0; d_s2[b] = 0; d_stable[b] = 0; d_armed[b] = 0;
                d_press[b] = 0; d_run[b] = 0;
            end
        end else begin
            old_tick = m_tick;
            pm = d_press[0];
            pp = d_press[1];
            m_tick = (((e - 1 - m_zero) % DIV) == DIV - 1);
            if (pm) begin
                m_mode  = m_mode + 2'd1;
                m_led   = (m_mode == 2'd3) ? 16'hFFFF : 16'h0001;
                m_right = 1'b0;
                m_zero  = e;
            end else if (old_tick && !m_paused) begin
                case (m_mode)
                    2'd0: m_led = (m_led << 1) | (m_led >> 15);
                    2'd1: m_led = (m_led >> 1) | (m_led << 15);
                    2'd3: m_led = ~m_led;
                    default: begin
                        if (m_led == 16'h8000) m_right = 1'b1;
                        else if (m_led == 16'h0001) m_right = 1'b0;
                        m_led = m_right ? (m_led >> 1) : (m_led << 1);
                    end
                endcase
            end
            if (pp) m_paused = !m_paused;
            deb_edge(0, btn_mode);
            deb_edge(1, btn_pause);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("cyc", {12'd0, led, mode, paused, tick}, {12'd0, m_led, m_mode, m_paused, m_tick});
    endtask

    task automatic wait_led(input logic [15:0] val, input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (led == val) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        repeat (6) cycle();
        btn_mode = 1'b0;
        repeat (4) cycle();
    endtask

    initial begin
        int          ticks;
        bit          found, top_ok, bot_ok, seen_top;
        logic [15:0] prev;
        int          len;

        // Reset state, then free-running ROTL.
        repeat (3) cycle();
        check("rst_state", {12'd0, led, mode, paused, tick}, {12'd0, 16'h0001, 2'd0, 1'b0, 1'b0});
        reset = 1'b0;
        ticks = 0;
        repeat (64) begin
            cycle();
            if (tick) ticks++;
        end
        check("tick_count", ticks, 4);
        check("rotl_led", led, 16'h0008);

        // Short glitch ignored; a long hold advances to ROTR.
        btn_mode = 1'b1;
        repeat (3) cycle();
        btn_mode = 1'b0;
        repeat (12) cycle();
        check("glitch_mode", mode, 2'd0);
        btn_mode = 1'b1;
        repeat (10) cycle();
        btn_mode = 1'b0;
        repeat (2) cycle();
        check("rotr_mode", mode, 2'd1);
        check("rotr_seed", led, 16'h0001);
        wait_led(16'h8000, 24, found);
        check("rotr_wrap", found, 1);

        // BOUNCE turning points.
        press_mode();
        check("bounce_mode", mode, 2'd2);
        top_ok = 0; bot_ok = 0; seen_top = 0;
        prev = led;
        repeat (40 * DIV) begin
            cycle();
            if (prev == 16'h8000 && led == 16'h4000) begin top_ok = 1; seen_top = 1; end
            if (seen_top && prev == 16'h0001 && led == 16'h0002) bot_ok = 1;
            prev = led;
        end
        check("bounce_top", top_ok, 1);
        check("bounce_bottom", bot_ok, 1);

        // Mode press pulse lands in the same cycle as tick.
        found = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            cycle();
            if (tick) begin found = 1; break; end
        end
        check("tick_seen", found, 1);
        repeat (10) cycle();
        btn_mode = 1'b1;
        repeat (7) cycle();
        btn_mode = 1'b0;
        check("coinc_mode", mode, 2'd3);
        check("coinc_seed", led, 16'hFFFF);
        repeat (3 * DIV) cycle();

        // Pause in ROTL at 0010.
        press_mode();
        check("rotl_again", {led, 14'd0, mode}, {16'h0001, 14'd0, 2'd0});
        wait_led(16'h0010, 8 * DIV, found);
        check("reach_0010", found, 1);
        btn_pause = 1'b1;
        repeat (6) cycle();
        btn_pause = 1'b0;
        repeat (3 * DIV) cycle();
        check("pause_hold", {led, 15'd0, paused}, {16'h0010, 15'd0, 1'b1});
        btn_pause = 1'b1;
        repeat (6) cycle();
        btn_pause = 1'b0;
        wait_led(16'h0020, 2 * DIV, found);
        check("resume_step", found, 1);
        check("resume_flag", paused, 1'b0);

        // Reset with btn_mode held in BOUNCE.
        press_mode();
        btn_mode = 1'b1;
        repeat (10) cycle();
        check("held_mode2", mode, 2'd2);
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (20) cycle();
        check("held_reset", mode, 2'd0);
        btn_mode = 1'b0;
        repeat (10) cycle();
        check("released", mode, 2'd0);
        press_mode();
        check("repress", mode, 2'd1);

        // Random buttons and occasional resets.
        for (int s = 0; s < 400; s++) begin
            len       = $urandom_range(1, 10);
            btn_mode  = ($urandom_range(0, 3) == 0);
            btn_pause = ($urandom_range(0, 4) == 0);
            reset     = ($urandom_range(0, 60) == 0);
            if (reset) len = $urandom_range(1, 3);
            repeat (len) cycle();
        end
        reset = 1'b0;
        btn_mode = 1'b0;
        btn_pause = 1'b0;
        repeat (20) cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 10_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, pattern step rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2.
REQ-003 Parameter DEBOUNCE_CYCLES, default 100_000, clock cycles a button level must be stable before it is accepted.
REQ-004 clk  input  1  the only clock for all logic (10 MHz system clock).
REQ-005 reset  input  1  synchronous reset, active-high.
REQ-006 btn_mode  input  1  raw, asynchronous mode-select button, active-high.
REQ-007 btn_pause  input  1  raw, asynchronous pause/run button, active-high.
REQ-008 led  output  16  registered LED pattern.
REQ-009 mode  output  2  current mode: 0 ROTL, 1 ROTR, 2 BOUNCE, 3 BLINK.
REQ-010 paused  output  1  1 while pattern stepping is frozen.
REQ-011 tick  output  1  registered one-cycle strobe at each step interval.

Function
REQ-012 The prescaler SHALL count 0..DIV-1, assert tick during the cycle after count equals DIV-1, and wrap to 0 on that cycle.
REQ-013 Each button SHALL pass through a 2-flop synchroniser, then through a debouncer that updates its stable level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-014 A rising edge of a debounced level SHALL produce a one-cycle press pulse; release SHALL produce no pulse.
REQ-015 A mode press SHALL advance mode ROTL->ROTR->BOUNCE->BLINK->ROTL, and SHALL wrap from BLINK to ROTL.
REQ-016 A mode press SHALL load the new mode's seed into led on the next cycle (ROTL/ROTR/BOUNCE 16'h0001, BLINK 16'hFFFF).
REQ-017 A mode press SHALL clear the prescaler to 0 and set the bounce direction to left.
REQ-018 A pause press SHALL toggle paused.
REQ-019 While paused=1, led SHALL hold its value on tick; the prescaler and tick SHALL keep running.
REQ-020 In the cycle after a tick with paused=0, led SHALL step by mode:
- ROTL: rotate left 1.
- ROTR: rotate right 1.
- BLINK: bitwise invert.
- BOUNCE: shift in the current direction.
REQ-021 In BOUNCE, direction SHALL flip to right when led==16'h8000 and to left when led==16'h0001, with the flip applied on the same step, so 8000->4000 and 0001->0002.
REQ-022 Mode press coincident with a tick: the mode change SHALL win, the seed SHALL be loaded, and no step SHALL occur.
REQ-023 Mode press while paused: the mode and seed SHALL update and paused SHALL remain 1.
REQ-024 Mode and pause presses in the same cycle SHALL both take effect.

Reset
REQ-025 While reset=1 at a clk edge:
- led=16'h0001, mode=0, paused=0, tick=0.
- prescaler=0, bounce direction=left.
- synchroniser flops, debounce counters and debounced levels = 0.
REQ-026 Reset asserted mid-operation SHALL override all other events in that cycle; no press pulse SHALL be generated from a button held through reset until it is released and pressed again.

Structure
REQ-027 Mode encodings, seed constants and the direction encoding SHALL live in shared package led_ctrl_pkg.
REQ-028 Synchroniser, debounce and edge detect SHALL form sub-module btn_debounce (params DEBOUNCE_CYCLES; ports clk, reset, btn_in, press), instantiated once per button.
REQ-029 The block SHALL contain only clk-domain synchronous logic, with no latches and no derived clocks.

Verification (CLK_HZ=16, TICK_HZ=1, DEBOUNCE_CYCLES=4)
REQ-030 Reset release, no buttons, 64 cycles -> tick every 16 cycles; led 0001->0002->0004->0008.
REQ-031 btn_mode high 3 cycles then low -> no mode change; held 10 cycles -> mode=1, led=0001, then 8000 at next tick.
REQ-032 BOUNCE for 32 ticks -> led reaches 8000, next 4000, reaches 0001, next 0002.
REQ-033 Pause press in ROTL at led=0010, wait 3 ticks -> led stays 0010 and paused=1; second press -> 0020 at next tick.
REQ-034 Mode press timed so its pulse coincides with tick in BOUNCE -> mode=3 and led=FFFF, no step; following ticks alternate 0000/FFFF.
REQ-035 Reset asserted while btn_mode held and mode=2 -> mode=0, led=0001; no mode change until release and re-press.
